// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Bundles the MEM-stage request/response signals and the
//               cyc/stb/ack data-memory bus used by mem_access_unit.
//               master : view of the access unit (drives bus, stall, load data)
//               slave  : view of the surroundings (pipeline + memory)
// Ports       : mem_ren/mem_wen/mem_addr/mem_din  -> request from MEM stage
//               mem_dout/mem_stall/addr_err/bus_err -> response to pipeline
//               bus_cyc/bus_stb/bus_we/bus_addr/bus_dout -> memory bus out
//               bus_din/bus_ack                      -> memory bus in
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_ren;
    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic                  mem_stall;
    logic                  addr_err;
    logic                  bus_err;
    logic                  bus_cyc;
    logic                  bus_stb;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_dout;
    logic [DATA_WIDTH-1:0] bus_din;
    logic                  bus_ack;

    modport master (
        input  mem_ren, mem_wen, mem_addr, mem_din, bus_din, bus_ack,
        output mem_dout, mem_stall, addr_err, bus_err,
               bus_cyc, bus_stb, bus_we, bus_addr, bus_dout
    );

    modport slave (
        output mem_ren, mem_wen, mem_addr, mem_din, bus_din, bus_ack,
        input  mem_dout, mem_stall, addr_err, bus_err,
               bus_cyc, bus_stb, bus_we, bus_addr, bus_dout
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Data-side memory responder for a 5-stage MIPS pipeline.
//               Turns an aligned MEM-stage load/store into one cyc/stb/ack
//               bus access, stalls the pipeline while it is outstanding and
//               presents load data for a single release cycle. Misaligned
//               requests are rejected with addr_err; an unacknowledged bus
//               access is aborted after TIMEOUT cycles with bus_err.
// Ports       : clk, rst (async, active-high)
//               mif (master modport of mem_access_unit_if)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_access_unit_if.master   mif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // Last counter value allowed before the access is abandoned.
    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]            r_state;
    logic [7:0]            r_cnt;
    logic [ADDR_WIDTH-1:2] r_addr;     // word address only; byte offset is always 0 on the bus
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_we;
    logic                  r_cyc;
    logic                  r_stb;
    logic [DATA_WIDTH-1:0] r_dout;

    logic w_req;
    logic w_aligned;

    assign w_req     = mif.mem_ren | mif.mem_wen;
    assign w_aligned = (mif.mem_addr[1:0] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && w_aligned) begin
                        r_addr  <= mif.mem_addr[ADDR_WIDTH-1:2];
                        r_din   <= mif.mem_din;
                        r_we    <= mif.mem_wen;   // store wins when both are set
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_BUS;
                    end
                end
                S_BUS: begin
                    // Ack is tested first so an ack on the final allowed
                    // cycle still completes the access.
                    if (mif.bus_ack) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_we  <= 1'b0;
                        if (!r_we) begin
                            r_dout <= mif.bus_din;
                        end
                        r_state <= S_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_dout  <= '0;
                        r_state <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                // The old request may still be present in DONE; returning to
                // IDLE for one cycle lets the pipeline move it on first.
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mif.mem_stall = ((r_state == S_IDLE) && w_req && w_aligned) || (r_state == S_BUS);
    assign mif.addr_err  = (r_state == S_IDLE) && w_req && !w_aligned;
    assign mif.bus_err   = (r_state == S_ERR);
    assign mif.mem_dout  = r_dout;
    assign mif.bus_cyc   = r_cyc;
    assign mif.bus_stb   = r_stb;
    assign mif.bus_we    = r_we;
    assign mif.bus_addr  = {r_addr, 2'b00};
    assign mif.bus_dout  = r_din;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. A driver issues
//               requests like a stalled pipeline would, a responder models
//               the memory with a per-access ack delay, and a monitor
//               compares every observed response with a queue of expected
//               transaction outcomes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int c_TIMEOUT = 4;
    localparam int K_DONE = 0;
    localparam int K_ERR  = 1;
    localparam int K_MIS  = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] dout;
        int          stalls;
        int          cycs;
    } exp_t;

    logic clk;
    logic rst;

    mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif ();

    mem_access_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (c_TIMEOUT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    logic [31:0] ref_dout = '0;
    int          cur_delay = 0;
    logic [31:0] cur_rdata = '0;
    logic        force_ack = 1'b0;
    logic        mon_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: ack after cur_delay wait cycles; random noise on ack
    // and read data while no cycle is active.
    initial begin
        int wcnt;
        wcnt = 0;
        mif.bus_ack = 1'b0;
        mif.bus_din = '0;
        forever begin
            @(negedge clk);
            if (mif.bus_cyc === 1'b1) begin
                mif.bus_ack = (wcnt == cur_delay);
                mif.bus_din = cur_rdata;
                wcnt++;
            end else begin
                wcnt = 0;
                mif.bus_ack = force_ack | ($urandom_range(0, 3) == 0);
                mif.bus_din = force_ack ? 32'hFFFF_FFFF : $urandom;
            end
        end
    end

    // Monitor: compares every response the DUT presents against the queue.
    initial begin
        int   stall_run;
        int   cyc_run;
        logic prev_stall;
        logic prev_cyc;
        exp_t e;
        stall_run  = 0;
        cyc_run    = 0;
        prev_stall = 1'b0;
        prev_cyc   = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mif.mem_stall) stall_run++;
                if (mif.bus_cyc)   cyc_run++;
                if (mif.bus_cyc && !prev_cyc) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bus_start: unexpected bus cycle at %0t", $time);
                    end else begin
                        e = q[0];
                        chk("start_kind_not_misaligned", 32'(e.kind == K_MIS), 32'd0);
                        chk("bus_stb", 32'(mif.bus_stb), 32'd1);
                        chk("bus_we", 32'(mif.bus_we), 32'(e.we));
                        if (e.we) chk("bus_dout", mif.bus_dout, e.wdata);
                    end
                end
                if (mif.bus_cyc && q.size() > 0) chk("bus_addr", mif.bus_addr, q[0].addr);
                if (mif.addr_err || (!mif.mem_stall && prev_stall)) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL response: unexpected response at %0t", $time);
                    end else begin
                        e = q.pop_front();
                        if (mif.addr_err) begin
                            chk("kind_misaligned", 32'(e.kind), 32'(K_MIS));
                            chk("mis_stall", 32'(mif.mem_stall), 32'd0);
                            chk("mis_bus_cyc", 32'(mif.bus_cyc), 32'd0);
                        end else begin
                            chk("kind_done_or_err", 32'(mif.bus_err ? K_ERR : K_DONE), 32'(e.kind));
                            chk("mem_dout", mif.mem_dout, e.dout);
                            chk("stall_cycles", 32'(stall_run), 32'(e.stalls));
                            chk("bus_cyc_cycles", 32'(cyc_run), 32'(e.cycs));
                            chk("done_bus_cyc", 32'(mif.bus_cyc), 32'd0);
                        end
                    end
                    stall_run = 0;
                    cyc_run   = 0;
                end
                prev_stall = mif.mem_stall;
                prev_cyc   = mif.bus_cyc;
            end
        end
    end

    // Reference outcome from the access rules, then drive the request until
    // the pipeline sees stall low and moves on.
    task automatic issue(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] din, input int delay, input logic [31:0] rdata);
        exp_t e;
        int   n;
        logic s;
        e.addr  = {addr[31:2], 2'b00};
        e.we    = wen;
        e.wdata = din;
        if (addr[1:0] != 2'b00) begin
            e.kind = K_MIS; e.cycs = 0; e.stalls = 0;
        end else if (delay <= c_TIMEOUT - 1) begin
            e.kind = K_DONE; e.cycs = delay + 1; e.stalls = delay + 2;
            if (!wen) ref_dout = rdata;
        end else begin
            e.kind = K_ERR; e.cycs = c_TIMEOUT; e.stalls = c_TIMEOUT + 1;
            ref_dout = '0;
        end
        e.dout = ref_dout;
        q.push_back(e);
        cur_delay    = delay;
        cur_rdata    = rdata;
        mif.mem_ren  = ren;
        mif.mem_wen  = wen;
        mif.mem_addr = addr;
        mif.mem_din  = din;
        n = 0;
        forever begin
            @(negedge clk);
            s = mif.mem_stall;
            @(posedge clk);
            #1;
            n++;
            if (!s) break;
            if (n > 40) begin
                checks++; errors++;
                $display("FAIL stall_bound: stall never released at %0t", $time);
                break;
            end
        end
    endtask

    task automatic idle_cycle();
        mif.mem_ren = 1'b0;
        mif.mem_wen = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mif.mem_ren  = 1'b0;
        mif.mem_wen  = 1'b0;
        mif.mem_addr = '0;
        mif.mem_din  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_bus_cyc", 32'(mif.bus_cyc), 32'd0);
        chk("rst_bus_stb", 32'(mif.bus_stb), 32'd0);
        chk("rst_bus_we", 32'(mif.bus_we), 32'd0);
        chk("rst_mem_dout", mif.mem_dout, 32'd0);
        chk("rst_stall", 32'(mif.mem_stall), 32'd0);
        chk("rst_errs", {30'd0, mif.addr_err, mif.bus_err}, 32'd0);

        // Reset in the middle of a bus access.
        cur_delay = 1000;
        mif.mem_ren  = 1'b1;
        mif.mem_addr = 32'h40;
        @(posedge clk); #1;
        chk("pre_rst_bus_cyc", 32'(mif.bus_cyc), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("async_rst_bus_cyc", 32'(mif.bus_cyc), 32'd0);
        chk("async_rst_bus_stb", 32'(mif.bus_stb), 32'd0);
        mif.mem_ren = 1'b0;
        #1;
        chk("async_rst_stall", 32'(mif.mem_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        force_ack = 1'b1;
        @(posedge clk); #1;
        force_ack = 1'b0;
        chk("late_ack_dout", mif.mem_dout, 32'd0);
        chk("late_ack_bus_cyc", 32'(mif.bus_cyc), 32'd0);
        chk("late_ack_stall", 32'(mif.mem_stall), 32'd0);
        ref_dout = '0;
        @(posedge clk); #1;

        mon_en = 1'b1;
        issue(1'b1, 1'b0, 32'h104, 32'h0, 3, 32'hDEAD_BEEF);
        idle_cycle();
        issue(1'b0, 1'b1, 32'h200, 32'h1234_5678, 0, 32'hAAAA_5555);
        idle_cycle();
        issue(1'b1, 1'b0, 32'h103, 32'h0, 0, 32'h0);
        idle_cycle();
        issue(1'b1, 1'b0, 32'h300, 32'h0, 1000, 32'h0);
        idle_cycle();
        issue(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h0BAD_F00D);
        issue(1'b0, 1'b1, 32'h14, 32'hCAFE_0014, 0, 32'h0);
        issue(1'b1, 1'b1, 32'h18, 32'h5A5A_5A5A, c_TIMEOUT - 1, 32'h0);

        for (int i = 0; i < 80; i++) begin
            int          op;
            logic [31:0] a;
            op = $urandom_range(1, 3);
            a  = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            issue(op[0], op[1], a, $urandom, $urandom_range(0, c_TIMEOUT + 1), $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();
        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
